// File: rtl/cpu_pkg.sv
// Shared types for the unified-memory arbiter: FSM state and current access owner.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data side wins unless fetch has been passed over
// STARVE_MAX times in a row while it was waiting.
module mem_arb_pick #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic             if_req,
   input  logic             dm_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             grant,
   output logic             pick_dm
);

   logic starved;

   assign starved = (starve_cnt >= CNT_W'(STARVE_MAX));
   assign pick_dm = dm_req & (~starved | ~if_req);
   assign grant   = pick_dm | if_req;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory with a
// level req/ack handshake per requester and a combinational pipeline stall.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              stall_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_t       state;
   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             grant;
   logic             pick_dm;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_W'(STARVE_MAX)) ? v : v + CNT_W'(1);
   endfunction

   mem_arb_pick #(
      .STARVE_MAX(STARVE_MAX),
      .CNT_W     (CNT_W)
   ) u_pick (
      .if_req    (if_req_i),
      .dm_req    (dm_req_i),
      .starve_cnt(starve_cnt),
      .grant     (grant),
      .pick_dm   (pick_dm)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         owner       <= OWN_IF;
         starve_cnt  <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         dm_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Request fields are latched here; later changes on the inputs are ignored.
               if (grant) begin
                  owner       <= pick_dm ? OWN_DM : OWN_IF;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= pick_dm & dm_we_i;
                  mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
                  mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
                  starve_cnt  <= (pick_dm & if_req_i) ? sat_inc(starve_cnt) : '0;
                  state       <= MEM;
               end
            end
            MEM: begin
               if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  if (!mem_we_o) begin
                     if (owner == OWN_DM) dm_rdata_o <= mem_rdata_i;
                     else                 if_rdata_o <= mem_rdata_i;
                  end
                  if_ack_o <= (owner == OWN_IF);
                  dm_ack_o <= (owner == OWN_DM);
                  state    <= ACK;
               end
            end
            ACK: begin
               if_ack_o <= 1'b0;
               dm_ack_o <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A requester stops stalling the pipeline in the cycle its ack is visible.
   assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule
